// File: rtl/elastic_pipe.sv
// elastic_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse and flush.
// Define ELASTIC_PIPE_OCC_EN to add the registered occupancy output (popcount of stage valids).
module elastic_pipe #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef ELASTIC_PIPE_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];

   logic [DEPTH-1:0] w_adv;
   logic             w_load0;
   logic [DEPTH-1:0] w_valid_nxt;
   logic [WIDTH-1:0] w_data_nxt [DEPTH];

   // w_adv[i]: stage i hands its content on this cycle; the chain runs from the output backwards.
   always_comb begin
      logic w_chain;
      w_chain        = out_ready | ~r_valid[DEPTH-1];
      w_adv[DEPTH-1] = w_chain;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         w_chain  = ~r_valid[i+1] | w_chain;
         w_adv[i] = w_chain;
      end
   end

   assign w_load0  = ~r_valid[0] | w_adv[0];
   assign in_ready = w_load0 & ~flush & ~reset;

   // NOTE: every output gets a default first so no path through this block infers a latch.
   always_comb begin
      w_valid_nxt = r_valid;
      w_data_nxt  = r_data;
      if (flush) begin
         w_valid_nxt = '0;
      end else begin
         if (w_load0) begin
            w_valid_nxt[0] = in_valid;
            if (in_valid) w_data_nxt[0] = in_data;
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (w_adv[i-1]) begin
               w_valid_nxt[i] = r_valid[i-1];
               if (r_valid[i-1]) w_data_nxt[i] = r_data[i-1];
            end
         end
      end
   end

   // NOTE: the data registers are cleared on reset as well, so out_data is 0 from the first edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_valid <= w_valid_nxt;
         r_data  <= w_data_nxt;
      end
   end

   assign out_valid = r_valid[DEPTH-1] & ~reset;
   assign out_data  = reset ? '0 : r_data[DEPTH-1];

`ifdef ELASTIC_PIPE_OCC_EN
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [OCC_W-1:0] r_occ;

   always_ff @(posedge clk) begin
      if (reset) r_occ <= '0;
      else       r_occ <= OCC_W'($countones(w_valid_nxt));
   end

   assign occupancy = reset ? '0 : r_occ;
`endif

`ifndef SYNTHESIS
   a_hold_stall: assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready && !flush) |=> $stable(out_data));
   a_flush_blocks_input: assert property (@(posedge clk) flush |-> !in_ready);
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: directed stimulus with a queue scoreboard; a negedge monitor pops on each output handshake.
// Occupancy checks are compiled in only when ELASTIC_PIPE_OCC_EN is defined.
module tb_elastic_pipe;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
`ifdef ELASTIC_PIPE_OCC_EN
   logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

   logic [WIDTH-1:0] sb [$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef ELASTIC_PIPE_OCC_EN
      ,
      .occupancy (occupancy)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   // Set inputs just after a rising edge, then wait to the falling edge to sample.
   task automatic drive(input logic rst, input logic fl, input logic v,
                        input logic [31:0] d, input logic ordy);
      reset     = rst;
      flush     = fl;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 16) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         tick();
         n++;
      end
      check({name, "_left"}, 32'(sb.size()), 32'd0);
   endtask

   // Monitor: each output handshake must match the oldest expected word.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_unexpected: actual=%0h expected=none at %0t", out_data, $time);
         end else begin
            check("out_data", out_data, sb.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] bp_d    [8];
      logic        bp_ordy [8];
      logic        bp_rdy  [8];

      // Reset held two cycles with a word offered.
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
         check_bit("rst_in_ready", in_ready, 1'b0);
         check_bit("rst_out_valid", out_valid, 1'b0);
         check("rst_out_data", out_data, 32'h0);
`ifdef ELASTIC_PIPE_OCC_EN
         check("rst_occ", 32'(occupancy), 32'd0);
`endif
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check_bit("rel_in_ready", in_ready, 1'b1);
      check_bit("rel_out_valid", out_valid, 1'b0);
      tick();

      // Streaming 1..8 with out_ready held high.
      for (int k = 0; k < 12; k++) begin
         drive(1'b0, 1'b0, k < 8, 32'(k + 1), 1'b1);
         if (k < 8) begin
            check_bit("stream_in_ready", in_ready, 1'b1);
            sb.push_back(32'(k + 1));
         end
         check_bit("stream_out_valid", out_valid, k >= 4);
`ifdef ELASTIC_PIPE_OCC_EN
         if (k >= 4 && k < 8) check("stream_occ", 32'(occupancy), 32'd4);
`endif
         tick();
      end
      drain("stream");

      // Backpressure: fill with 1..4, stall on 5, then release.
      bp_d    = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd5, 32'd5, 32'd6};
      bp_ordy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      bp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b0, 1'b1, bp_d[k], bp_ordy[k]);
         check_bit("bp_in_ready", in_ready, bp_rdy[k]);
         if (bp_rdy[k]) sb.push_back(bp_d[k]);
         if (k == 4 || k == 5) begin
            check("bp_hold_data", out_data, 32'd1);
`ifdef ELASTIC_PIPE_OCC_EN
            check("bp_occ", 32'(occupancy), 32'd4);
`endif
         end
         tick();
      end
      drain("bp");

      // Bubble collapse: 0xA, two idle cycles, 0xB, then six stalled cycles.
      drive(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
      check_bit("bub_in_ready_a", in_ready, 1'b1);
      sb.push_back(32'hA);
      tick();
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
      check_bit("bub_in_ready_b", in_ready, 1'b1);
      sb.push_back(32'hB);
      tick();
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         if (k == 5) begin
            check("bub_head", out_data, 32'hA);
`ifdef ELASTIC_PIPE_OCC_EN
            check("bub_occ", 32'(occupancy), 32'd2);
`endif
         end
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         check_bit("bub_out_valid", out_valid, k < 2);
         tick();
      end
      check("bub_left", 32'(sb.size()), 32'd0);

      // Flush collision: three words held, flush while 0xDEAD is offered.
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b1, 32'h11 * 32'(k + 1), 1'b0);
         check_bit("fl_fill_ready", in_ready, 1'b1);
         sb.push_back(32'h11 * 32'(k + 1));
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b0);
      check_bit("fl_in_ready", in_ready, 1'b0);
`ifdef ELASTIC_PIPE_OCC_EN
      check("fl_occ_before", 32'(occupancy), 32'd3);
`endif
      tick();
      sb.delete();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check_bit("fl_out_valid", out_valid, 1'b0);
      check_bit("fl_in_ready_after", in_ready, 1'b1);
`ifdef ELASTIC_PIPE_OCC_EN
      check("fl_occ_after", 32'(occupancy), 32'd0);
`endif
      tick();
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         tick();
      end
      check_bit("fl_quiet", out_valid, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'h77, 1'b1);
      check_bit("fl_resume_ready", in_ready, 1'b1);
      sb.push_back(32'h77);
      tick();
      drain("fl_resume");

      // Reset mid-stream discards in-flight words.
      drive(1'b0, 1'b0, 1'b1, 32'h5A, 1'b0);
      sb.push_back(32'h5A);
      tick();
      drive(1'b0, 1'b0, 1'b1, 32'h5B, 1'b0);
      sb.push_back(32'h5B);
      tick();
      drive(1'b1, 1'b0, 1'b1, 32'hEE, 1'b1);
      check_bit("mid_rst_in_ready", in_ready, 1'b0);
      check_bit("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_out_data", out_data, 32'h0);
      tick();
      sb.delete();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_bit("mid_rel_in_ready", in_ready, 1'b1);
`ifdef ELASTIC_PIPE_OCC_EN
      check("mid_rel_occ", 32'(occupancy), 32'd0);
`endif
      tick();
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         tick();
      end
      check_bit("mid_quiet", out_valid, 1'b0);
      check("final_left", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
